user_rst_sequencer: RTL

USER_RST_SEQUENCER -- requirements
Module: user_rst_sequencer

---
 rtl/user_rst_sequencer_pkg.sv | 19 +
 rtl/user_rst_seq_timer.sv | 30 +++
 rtl/user_rst_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/user_rst_sequencer_pkg.sv
// Shared definitions for the staged user-reset sequencer: state encodings,
// fault counter sizing and a small sizing helper.
package user_rst_sequencer_pkg;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StStable  = 2'd1,
        StRelease = 2'd2,
        StRun     = 2'd3
    } seq_state_e;

    localparam int unsigned FaultCntW = 8;
    localparam logic [FaultCntW-1:0] FaultCntMax = 8'd255;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/user_rst_seq_timer.sv
// Loadable down-counter shared between lock-stability counting and stage-gap
// counting; done flags the edge on which the count expires.
module user_rst_seq_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    // A decrement taken while the count is 1 is the final one.
    assign done = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/user_rst_sequencer.sv
// Releases NUM_STAGES active-high resets one by one once lock_in has been
// stable long enough, and drops all of them one cycle after a lock loss.
module user_rst_sequencer
    import user_rst_sequencer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES    = 64,
    parameter int unsigned NUM_STAGES    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock_in,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [FaultCntW-1:0]  fault_cnt
);

    localparam int unsigned CntW = $clog2(max_u(STABLE_CYCLES, GAP_CYCLES) + 1);
    // The edge that enters STABLE already counts as the first stable cycle.
    localparam logic [CntW-1:0] StableLoad = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad    = CntW'(GAP_CYCLES);

    seq_state_e state_q;

    logic            tmr_clr;
    logic            tmr_load;
    logic            tmr_dec;
    logic [CntW-1:0] tmr_val;
    logic            tmr_done;

    logic                  release_now;
    logic                  lock_lost;
    logic                  last_stage;
    logic [NUM_STAGES-1:0] rel_next;

    user_rst_seq_timer #(
        .WIDTH (CntW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Stages release LSB first, so each release shifts one more zero in.
    assign rel_next   = rst_out << 1;
    assign last_stage = (rel_next == '0);
    assign lock_lost  = !lock_in && ((state_q == StRelease) || (state_q == StRun));

    always_comb begin
        tmr_clr     = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        tmr_val     = GapLoad;
        release_now = 1'b0;
        unique case (state_q)
            StHold: begin
                if (!lock_in) begin
                    tmr_clr = 1'b1;
                end else if (STABLE_CYCLES == 1) begin
                    release_now = 1'b1;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = StableLoad;
                end
            end
            StStable, StRelease: begin
                if (!lock_in) begin
                    tmr_clr = 1'b1;
                end else if (tmr_done) begin
                    release_now = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StRun: begin
                if (!lock_in) begin
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                tmr_clr = 1'b1;
            end
        endcase
        if (release_now && !last_stage) begin
            tmr_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StHold;
            rst_out   <= '1;
            ready     <= 1'b0;
            fault_cnt <= '0;
        end else if (lock_lost) begin
            state_q <= StHold;
            rst_out <= '1;
            ready   <= 1'b0;
            if (fault_cnt != FaultCntMax) begin
                fault_cnt <= fault_cnt + FaultCntW'(1);
            end
        end else if (release_now) begin
            rst_out <= rel_next;
            ready   <= last_stage;
            state_q <= last_stage ? StRun : StRelease;
        end else if ((state_q == StHold) && lock_in) begin
            state_q <= StStable;
        end else if ((state_q == StStable) && !lock_in) begin
            state_q <= StHold;
        end
    end

endmodule
